// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory path.
// Contents: FSM state type for dmem_ctrl, access-type encodings shared with
// the store and load units, and the wait-counter width.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_t;

  // Access type carried on mem_rw_mode.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Wait counter covers WAIT_STATES in 0..15.
  localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the issuing stage and dmem_ctrl.
// master: drives mem_req, mem_rw_mode, mem_addr, mem_write_data, mem_byte_en;
//         observes mem_read_data, mem_ready, mem_err, mem_busy.
// slave : the opposite direction (dmem_ctrl side).
interface dmem_ctrl_if;

  logic        mem_req;
  logic        mem_rw_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        mem_err;
  logic        mem_busy;

  modport master (
    output mem_req,
    output mem_rw_mode,
    output mem_addr,
    output mem_write_data,
    output mem_byte_en,
    input  mem_read_data,
    input  mem_ready,
    input  mem_err,
    input  mem_busy
  );

  modport slave (
    input  mem_req,
    input  mem_rw_mode,
    input  mem_addr,
    input  mem_write_data,
    input  mem_byte_en,
    output mem_read_data,
    output mem_ready,
    output mem_err,
    output mem_busy
  );

endinterface

// File: rtl/dmem_ram.sv
// Word array with per-byte write enables and a registered read port.
// Ports:
//   clk   - rising-edge clock
//   idx   - word index shared by the read and write ports
//   we    - byte write enables, bit k writes bits [8k+7:8k]
//   wdata - write data, lane aligned
//   re    - read enable; when low the read register loads zero
//   rdata - registered read data
// Contents are not reset.
module dmem_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned IdxW  = $clog2(Depth)
) (
  input  logic            clk,
  input  logic [IdxW-1:0] idx,
  input  logic [3:0]      we,
  input  logic [31:0]     wdata,
  input  logic            re,
  output logic [31:0]     rdata
);

  logic [31:0] mem [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) begin
        mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    // Zero when idle so the output reads as 0 outside read completions.
    rdata_q <= re ? mem[idx] : '0;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-outstanding request handshake, fixed wait
// states, byte-enabled writes and full-word reads on an internal array.
// Ports:
//   i_clk - rising-edge clock
//   i_rst - synchronous active-low reset
//   bus   - dmem_ctrl_if.slave: request (mem_req/rw_mode/addr/write_data/
//           byte_en) and registered response (mem_read_data/ready/err) plus
//           mem_busy (high whenever the FSM is outside IDLE)
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic        i_clk,
  input logic        i_rst,
  dmem_ctrl_if.slave bus
);

  import dmem_ctrl_pkg::*;

  localparam int unsigned       IdxW       = $clog2(DEPTH_WORDS);
  localparam logic [WCNT_W-1:0] WaitStates = 4'(WAIT_STATES);

  dmem_state_t       state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              ready_q;
  logic              err_q;

  // Request latch.
  logic              rw_q;
  logic              ok_q;
  logic [IdxW-1:0]   idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  // Range check on the live address; wrap below BASE_ADDR fails the check.
  logic [31:0]     off_in;
  logic            ok_in;
  logic [IdxW-1:0] idx_in;

  assign off_in = bus.mem_addr - BASE_ADDR;
  assign ok_in  = (off_in >> (IdxW + 2)) == '0;
  assign idx_in = off_in[IdxW+1:2];

  // With zero wait states the access happens on the accept edge, so the
  // array must see the live request in IDLE rather than the latch.
  logic            rw_src;
  logic            ok_src;
  logic [IdxW-1:0] idx_src;
  logic [31:0]     wdata_src;
  logic [3:0]      be_src;

  always_comb begin
    rw_src    = rw_q;
    ok_src    = ok_q;
    idx_src   = idx_q;
    wdata_src = wdata_q;
    be_src    = be_q;
    if (state_q == StIdle) begin
      rw_src    = bus.mem_rw_mode;
      ok_src    = ok_in;
      idx_src   = idx_in;
      wdata_src = bus.mem_write_data;
      be_src    = bus.mem_byte_en;
    end
  end

  // High on the edge that enters RESP; the array access happens on that edge.
  logic enter_resp;

  always_comb begin
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle:  enter_resp = bus.mem_req && (WaitStates == '0);
      StWait:  enter_resp = (wcnt_q == 4'd1);
      default: enter_resp = 1'b0;
    endcase
    // A reset edge drops any in-flight access.
    if (!i_rst) begin
      enter_resp = 1'b0;
    end
  end

  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign ram_we = (enter_resp && ok_src && (rw_src == MEM_WRITE)) ? be_src : 4'b0000;
  assign ram_re = enter_resp && ok_src && (rw_src == MEM_READ);

  dmem_ram #(
    .Depth (DEPTH_WORDS),
    .IdxW  (IdxW)
  ) u_ram (
    .clk   (i_clk),
    .idx   (idx_src),
    .we    (ram_we),
    .wdata (wdata_src),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rw_q    <= MEM_READ;
      ok_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      ready_q <= enter_resp;
      err_q   <= enter_resp && !ok_src;
      unique case (state_q)
        StIdle: begin
          if (bus.mem_req) begin
            rw_q    <= bus.mem_rw_mode;
            ok_q    <= ok_in;
            idx_q   <= idx_in;
            wdata_q <= bus.mem_write_data;
            be_q    <= bus.mem_byte_en;
            wcnt_q  <= WaitStates;
            state_q <= (WaitStates == '0) ? StResp : StWait;
          end
        end
        StWait: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_read_data = ram_rdata;
  assign bus.mem_ready     = ready_q;
  assign bus.mem_err       = err_q;
  assign bus.mem_busy      = (state_q != StIdle);

endmodule
